// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared state encoding and width helpers
// for the LDPC syndrome checker slice.
package ldpc_pkg;

   typedef enum logic [4:0] {
      S_IDLE = 5'b00001,
      S_PRP  = 5'b00010,
      S_CLC  = 5'b00100,
      S_ACC  = 5'b01000,
      S_DONE = 5'b10000
   } state_t;

   function automatic int bits_for(input int n);
      return $clog2(n + 1);
   endfunction

   function automatic int wb_of(input int z);
      return bits_for(z);
   endfunction

   function automatic int wr_of(input int rows);
      return bits_for(rows);
   endfunction

   function automatic int wc_of(input int cols);
      return bits_for(cols);
   endfunction

   function automatic int ww_of(input int rows, input int z);
      return bits_for(rows * z);
   endfunction

endpackage

// File: rtl/ldpc_syndrome_checker_rotate.sv
// rotate_left_vector: circulant rotator, rotates the low
// 'size' bits of data left by 'shift'; upper bits read zero.
module rotate_left_vector #(
   parameter int W  = 8,
   parameter int SW = 4
) (
   input  logic [W-1:0]  data,
   input  logic [SW-1:0] shift,
   input  logic [SW-1:0] size,
   output logic [W-1:0]  rot
);

   localparam int IW = (W > 1) ? $clog2(W) : 1;

   int src;

   // each output bit pulls the input bit 'shift' places below it
   always_comb begin
      rot = '0;
      src = 0;
      for (int i = 0; i < W; i++) begin
         src = i - int'(shift);
         if (src < 0) src = src + int'(size);
         if (i < int'(size) && src >= 0 && src < W)
            rot[i] = data[IW'(src)];
      end
   end

endmodule

// File: rtl/ldpc_syndrome_checker.sv
// ldpc_syndrome_checker: quasi-cyclic H*c syndrome check,
// LANES block-rows per pass, early-exit or full-weight mode.
module ldpc_syndrome_checker
   import ldpc_pkg::*;
#(
   parameter int MAX_BLOCK_SIZE = 8,
   parameter int MAX_ROWS = 8,
   parameter int MAX_COLS = 8,
   parameter int LANES = 2,
   localparam int WB = wb_of(MAX_BLOCK_SIZE),
   localparam int WR = wr_of(MAX_ROWS),
   localparam int WC = wc_of(MAX_COLS),
   localparam int WW = ww_of(MAX_ROWS, MAX_BLOCK_SIZE)
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic abort,
   input  logic full_mode,
   input  logic [MAX_COLS*MAX_BLOCK_SIZE-1:0] codeword_in,
   input  logic [MAX_ROWS*MAX_COLS*WB-1:0] h_shift_in,
   input  logic [MAX_ROWS*MAX_COLS-1:0] h_mask_in,
   input  logic [WB-1:0] block_size_in,
   input  logic [WR-1:0] rows_in,
   input  logic [WC-1:0] cols_in,
   output logic ready,
   output logic done,
   output logic valid,
   output logic cfg_err,
   output logic [WW-1:0] syn_weight,
   output logic [WR-1:0] fail_row
);

   localparam int MBS = MAX_BLOCK_SIZE;

   state_t state, state_nx;

   logic [MAX_COLS*MBS-1:0] cw_q;
   logic [WB-1:0] bs_q;
   logic [WR-1:0] rows_q;
   logic [WC-1:0] cols_q;
   logic full_q;
   logic [WC-1:0] col_q;
   logic [WR-1:0] grp_q;
   logic [MBS-1:0] syn_q [LANES];
   logic [WW-1:0] acc_q;
   logic [WR-1:0] fr_q;
   logic failed_q;

   logic [MBS-1:0] blk;
   logic [WB-1:0] sh [LANES];
   logic mk [LANES];
   logic act [LANES];
   logic [MBS-1:0] rot [LANES];
   logic [WW-1:0] cnt [LANES];
   logic [WW-1:0] acc_nx;
   logic [WR-1:0] fr_nx;
   logic any_fail;
   logic last_grp;
   logic last_col;
   logic cfg_bad;
   logic accept;

   function automatic logic [WW-1:0] popcnt(
      input logic [MBS-1:0] v,
      input logic [WB-1:0] n
   );
      logic [WW-1:0] c;
      c = '0;
      for (int i = 0; i < MBS; i++)
         if (i < int'(n) && v[i]) c = c + WW'(1);
      return c;
   endfunction

   assign cfg_bad = (block_size_in == '0) ||
                    (int'(block_size_in) > MAX_BLOCK_SIZE) ||
                    (rows_in == '0) ||
                    (int'(rows_in) > MAX_ROWS) ||
                    (cols_in == '0) ||
                    (int'(cols_in) > MAX_COLS);
   assign accept   = (state == S_IDLE) && start && !abort;
   assign last_col = int'(col_q) == int'(cols_q) - 1;
   assign last_grp = (int'(grp_q) + 1) * LANES >= int'(rows_q);

   // codeword block for the current column
   always_comb begin
      blk = '0;
      for (int j = 0; j < MAX_COLS; j++)
         if (int'(col_q) == j) blk = cw_q[j*MBS +: MBS];
   end

   // per-lane H entry lookup: shift, mask, row-in-range
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         sh[l]  = '0;
         mk[l]  = 1'b1;
         act[l] = (int'(grp_q) * LANES + l) < int'(rows_q);
         for (int r = 0; r < MAX_ROWS; r++)
            for (int j = 0; j < MAX_COLS; j++)
               if ((int'(grp_q) * LANES + l) == r &&
                   int'(col_q) == j) begin
                  sh[l] = h_shift_in[(r*MAX_COLS+j)*WB +: WB];
                  mk[l] = h_mask_in[r*MAX_COLS+j];
               end
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      rotate_left_vector #(
         .W  (MBS),
         .SW (WB)
      ) u_rot (
         .data  (blk),
         .shift (sh[l]),
         .size  (bs_q),
         .rot   (rot[l])
      );
   end

   // group accumulation: weights and lowest failing row
   always_comb begin
      acc_nx   = acc_q;
      fr_nx    = fr_q;
      any_fail = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         cnt[l] = popcnt(syn_q[l], bs_q);
         if (act[l]) begin
            acc_nx = acc_nx + cnt[l];
            if (cnt[l] != '0 && !any_fail) begin
               any_fail = 1'b1;
               if (!failed_q)
                  fr_nx = WR'(int'(grp_q) * LANES + l);
            end
         end
      end
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // next state and handshake outputs
   always_comb begin
      state_nx = state;
      ready    = (state == S_IDLE);
      done     = (state == S_DONE);
      if (abort && state != S_IDLE) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE:
               if (start && !abort)
                  state_nx = cfg_bad ? S_DONE : S_PRP;
            S_PRP:  state_nx = S_CLC;
            S_CLC:  if (last_col) state_nx = S_ACC;
            S_ACC:
               if (last_grp || (any_fail && !full_q))
                  state_nx = S_DONE;
               else
                  state_nx = S_PRP;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   // datapath: capture, lane syndromes, results
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cw_q       <= '0;
         bs_q       <= '0;
         rows_q     <= '0;
         cols_q     <= '0;
         full_q     <= 1'b0;
         col_q      <= '0;
         grp_q      <= '0;
         acc_q      <= '0;
         fr_q       <= '0;
         failed_q   <= 1'b0;
         for (int l = 0; l < LANES; l++) syn_q[l] <= '0;
         valid      <= 1'b0;
         cfg_err    <= 1'b0;
         syn_weight <= '0;
         fail_row   <= '0;
      end else if (!abort) begin
         if (accept) begin
            cw_q     <= codeword_in;
            bs_q     <= block_size_in;
            rows_q   <= rows_in;
            cols_q   <= cols_in;
            full_q   <= full_mode;
            grp_q    <= '0;
            acc_q    <= '0;
            fr_q     <= rows_in;
            failed_q <= 1'b0;
            cfg_err  <= cfg_bad;
            if (cfg_bad) begin
               valid      <= 1'b0;
               syn_weight <= '0;
               fail_row   <= '0;
            end
         end
         if (state == S_PRP) begin
            col_q <= '0;
            for (int l = 0; l < LANES; l++) syn_q[l] <= '0;
         end
         if (state == S_CLC) begin
            for (int l = 0; l < LANES; l++)
               if (act[l] && !mk[l])
                  syn_q[l] <= syn_q[l] ^ rot[l];
            col_q <= col_q + WC'(1);
         end
         if (state == S_ACC) begin
            acc_q    <= acc_nx;
            fr_q     <= fr_nx;
            failed_q <= failed_q | any_fail;
            grp_q    <= grp_q + WR'(1);
            if (state_nx == S_DONE) begin
               valid      <= (acc_nx == '0) && !(failed_q || any_fail);
               syn_weight <= acc_nx;
               fail_row   <= fr_nx;
            end
         end
      end
   end

endmodule

// File: tb/tb_ldpc_syndrome_checker.sv
// tb_ldpc_syndrome_checker: directed + random runs against a
// reference syndrome model with an expected-result queue.
module tb_ldpc_syndrome_checker;

   localparam int MBS = 8;
   localparam int MR  = 8;
   localparam int MC  = 8;
   localparam int L   = 2;
   localparam int WB  = 4;
   localparam int WR  = 4;
   localparam int WC  = 4;
   localparam int WW  = 7;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic full_mode = 1'b0;
   logic [MC*MBS-1:0] codeword = '0;
   logic [MR*MC*WB-1:0] h_shift = '0;
   logic [MR*MC-1:0] h_mask = '0;
   logic [WB-1:0] block_size = '0;
   logic [WR-1:0] rows = '0;
   logic [WC-1:0] cols = '0;
   logic ready, done, valid, cfg_err;
   logic [WW-1:0] syn_weight;
   logic [WR-1:0] fail_row;

   typedef struct {
      int cyc;
      logic v;
      logic [WW-1:0] w;
      logic [WR-1:0] fr;
      logic ce;
      logic wf;
   } exp_t;

   exp_t sbq[$];
   exp_t last;
   int total = 0;
   int bad = 0;

   ldpc_syndrome_checker #(
      .MAX_BLOCK_SIZE (MBS),
      .MAX_ROWS       (MR),
      .MAX_COLS       (MC),
      .LANES          (L)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .abort         (abort),
      .full_mode     (full_mode),
      .codeword_in   (codeword),
      .h_shift_in    (h_shift),
      .h_mask_in     (h_mask),
      .block_size_in (block_size),
      .rows_in       (rows),
      .cols_in       (cols),
      .ready         (ready),
      .done          (done),
      .valid         (valid),
      .cfg_err       (cfg_err),
      .syn_weight    (syn_weight),
      .fail_row      (fail_row)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
      end
   endtask

   function automatic exp_t predict();
      exp_t e;
      int rw [MR];
      int bs, nr, nc, tot, fr, g, gn, s, w;
      logic [MBS-1:0] syn;
      bs = int'(block_size);
      nr = int'(rows);
      nc = int'(cols);
      e.ce = 1'b0;
      e.wf = 1'b1;
      if (bs == 0 || bs > MBS || nr == 0 || nr > MR ||
          nc == 0 || nc > MC) begin
         e.ce = 1'b1;
         e.v = 1'b0;
         e.w = '0;
         e.fr = '0;
         e.wf = 1'b0;
         e.cyc = 1;
         return e;
      end
      for (int r = 0; r < MR; r++) rw[r] = 0;
      for (int r = 0; r < nr; r++) begin
         syn = '0;
         for (int j = 0; j < nc; j++) begin
            if (!h_mask[r*MC+j]) begin
               s = int'(h_shift[(r*MC+j)*WB +: WB]);
               for (int k = 0; k < bs; k++)
                  if (codeword[j*MBS+k])
                     syn[(k+s)%bs] = ~syn[(k+s)%bs];
            end
         end
         for (int k = 0; k < bs; k++) rw[r] += int'(syn[k]);
      end
      tot = 0;
      fr = nr;
      for (int r = 0; r < nr; r++) begin
         tot += rw[r];
         if (rw[r] != 0 && fr == nr) fr = r;
      end
      gn = (nr + L - 1) / L;
      if (full_mode || fr == nr) begin
         e.w = WW'(tot);
         e.cyc = gn * (nc + 2) + 1;
      end else begin
         g = fr / L;
         w = 0;
         for (int r = g * L; r < g * L + L && r < nr; r++)
            w += rw[r];
         e.w = WW'(w);
         e.cyc = (g + 1) * (nc + 2) + 1;
      end
      e.v = (fr == nr);
      e.fr = WR'(fr);
      return e;
   endfunction

   task automatic rand_h(input int bs);
      for (int i = 0; i < MR * MC; i++) begin
         h_shift[i*WB +: WB] = WB'($urandom_range(bs - 1, 0));
         h_mask[i] = 1'($urandom_range(1, 0));
      end
   endtask

   task automatic run(input string tag, input bit ghost);
      int cyc;
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      sbq.push_back(predict());
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      chk({tag, "_busy_ready"}, 32'(ready), 32'(sbq[0].ce ? 1'b0 : 1'b0));
      while (!done && cyc < 300) begin
         start = (ghost && cyc == 3);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk({tag, "_done"}, 32'(done), 32'd1);
      e = sbq.pop_front();
      chk({tag, "_cycle"}, 32'(cyc), 32'(e.cyc));
      chk({tag, "_valid"}, 32'(valid), 32'(e.v));
      chk({tag, "_cfg_err"}, 32'(cfg_err), 32'(e.ce));
      if (e.wf) begin
         chk({tag, "_weight"}, 32'(syn_weight), 32'(e.w));
         chk({tag, "_fail_row"}, 32'(fail_row), 32'(e.fr));
      end
      last = e;
      @(negedge clk);
      chk({tag, "_idle_ready"}, 32'(ready), 32'd1);
   endtask

   initial begin
      int n;
      last.v = 1'b0;
      last.w = '0;
      last.fr = '0;
      last.ce = 1'b0;
      last.wf = 1'b1;
      last.cyc = 0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_cfg_err", 32'(cfg_err), 32'd0);
      chk("rst_weight", 32'(syn_weight), 32'd0);
      chk("rst_fail_row", 32'(fail_row), 32'd0);
      rst = 1'b0;

      block_size = 4'd4;
      rows = 4'd2;
      cols = 4'd3;
      full_mode = 1'b1;
      codeword = '0;
      rand_h(4);
      run("zero_cw", 1'b0);
      chk("zero_cw_fixed_cycle", 32'(last.cyc), 32'd6);

      h_mask[0] = 1'b0;
      h_mask[MC] = 1'b0;
      codeword = '0;
      codeword[0] = 1'b1;
      run("one_flip", 1'b0);

      rows = 4'd4;
      full_mode = 1'b0;
      h_mask = '1;
      h_mask[3*MC] = 1'b0;
      run("row3_early", 1'b1);

      rows = 4'd2;
      full_mode = 1'b1;
      rand_h(4);
      for (int j = 0; j < MC; j++) begin
         h_mask[j] = 1'b0;
         h_mask[MC+j] = 1'b1;
      end
      codeword = {$urandom, $urandom};
      run("mask_row1", 1'b0);

      for (int t = 0; t < 5; t++) begin
         n = $urandom_range(MBS, 1);
         block_size = WB'(n);
         rows = WR'($urandom_range(MR, 1));
         cols = WC'($urandom_range(MC, 1));
         full_mode = 1'($urandom_range(1, 0));
         codeword = {$urandom, $urandom};
         rand_h(n);
         run("random", 1'b0);
      end

      block_size = 4'd0;
      run("cfg_bs0", 1'b0);
      block_size = 4'd4;
      rows = 4'd9;
      run("cfg_rows9", 1'b0);
      rows = 4'd3;
      cols = 4'd2;
      full_mode = 1'b1;
      codeword = {$urandom, $urandom};
      rand_h(4);
      run("cfg_clear", 1'b0);

      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("abort_beats_start", 32'(ready), 32'd1);

      rows = 4'd6;
      cols = 4'd5;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_valid", 32'(valid), 32'(last.v));
      chk("abort_weight", 32'(syn_weight), 32'(last.w));
      chk("abort_fail_row", 32'(fail_row), 32'(last.fr));
      chk("abort_cfg_err", 32'(cfg_err), 32'(last.ce));
      n = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) n++;
      end
      chk("abort_no_done", 32'(n), 32'd0);

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_ready", 32'(ready), 32'd1);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_valid", 32'(valid), 32'd0);
      chk("midrst_cfg_err", 32'(cfg_err), 32'd0);
      chk("midrst_weight", 32'(syn_weight), 32'd0);
      chk("midrst_fail_row", 32'(fail_row), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) n++;
      end
      chk("midrst_no_done", 32'(n), 32'd0);
      chk("midrst_idle", 32'(ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ldpc_syndrome_checker.md
# ldpc_syndrome_checker

Parametrised LDPC parity checker: computes the syndrome H·c of a hard-decision codeword against a quasi-cyclic H matrix (circulant shift per entry, per-entry null-block mask), processing `LANES` check-row blocks in parallel. It supports early-exit and full-weight modes and reports pass/fail, syndrome weight and first failing row. It sits after the hard-decision stage and feeds the decoder's iteration-stop logic; it reuses the existing circulant rotator.

## Interface
- `MAX_BLOCK_SIZE`, 8: maximum circulant size Z.
- `MAX_ROWS`, 8: maximum H block-rows.
- `MAX_COLS`, 8: maximum H block-columns.
- `LANES`, 2: block-rows evaluated per pass; 1 ≤ LANES ≤ MAX_ROWS.
- Derived: WB = clog2(MAX_BLOCK_SIZE+1), WR = clog2(MAX_ROWS+1), WC = clog2(MAX_COLS+1), WW = clog2(MAX_ROWS·MAX_BLOCK_SIZE+1).

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request; accepted only when `ready`=1.
- `abort` in 1: cancel the running check.
- `full_mode` in 1: 0 = stop at first failing row; 1 = evaluate all rows, accumulate weight.
- `codeword_in` in MAX_COLS·MAX_BLOCK_SIZE: codeword; block j at bits [j·MAX_BLOCK_SIZE +: MAX_BLOCK_SIZE].
- `h_shift_in` in MAX_ROWS·MAX_COLS·WB: shift of entry (r,j) at index r·MAX_COLS+j.
- `h_mask_in` in MAX_ROWS·MAX_COLS: 1 = entry (r,j) is a zero block.
- `block_size_in` in WB, `rows_in` in WR, `cols_in` in WC: active dimensions.
- `ready` out 1: in IDLE.
- `done` out 1: one-cycle completion pulse.
- `valid` out 1: all evaluated syndromes zero.
- `cfg_err` out 1: illegal dimensions on last start.
- `syn_weight` out WW: unsatisfied-check count (full mode), count of the first failing group (early mode).
- `fail_row` out WR: lowest failing check-block-row index; rows_in if none.

## Operation
- States: IDLE, PRP, CLC, ACC, DONE.
- IDLE: `start` captures codeword, dimensions, `full_mode` into registers; H inputs must be held stable until `done`. Next state PRP, or DONE with cfg_err=1 if block_size_in, rows_in or cols_in is 0 or exceeds its MAX.
- PRP: clear LANES lane syndromes, col_index ← 0.
- CLC: for each lane l, row r = group·LANES+l: lane_syn ^= rotl(block[col_index], shift(r,col_index), block_size) unless masked or r ≥ rows. One column per cycle; leave after col_index = cols−1.
- ACC: per lane, popcount of bits [block_size−1:0] only; add active-lane counts to weight; update fail_row with lowest failing r if none recorded. Go DONE if last group, or if failure found and full_mode=0; else PRP, group+1.
- DONE: `done`=1, valid = (weight==0 and no failure), back to IDLE. Results hold until next accepted start.
- Shift entries must be < block_size; not checked.
- `start` while not ready: ignored. `abort` in any non-IDLE state: IDLE next cycle, no `done`, outputs keep prior values; abort beats start in the same cycle.

## Timing
- Reset values: ready=1 (state IDLE), done=0, valid=0, cfg_err=0, syn_weight=0, fail_row=0.
- G = ceil(rows/LANES). Start accepted at edge 0; full-mode `done` high during cycle G·(cols+2)+1.
- Early mode, failure in group g (0-based): `done` at cycle (g+1)·(cols+2)+1.
- cfg_err path: `done` in cycle 1.
- `ready` low from cycle after accept through the DONE cycle; new start accepted the cycle after DONE.
- Reset mid-operation: immediate return to reset values.

## Structure
- Shared package `ldpc_pkg`: state encoding (one-hot), width helper functions (WB/WR/WC/WW).
- Sub-module: `rotate_left_vector`, one instance per lane (LANES instances).
- Popcount as a local function; no other sub-modules.

## Test plan
- Z=4, rows=2, cols=3, LANES=2, all-zero codeword, any H -> done at cycle 6, valid=1, syn_weight=0, fail_row=2.
- Same H, single bit flipped in block 0 seen by rows 0 and 1, full_mode=1 -> valid=0, syn_weight=2, fail_row=0.
- rows=4, LANES=2, error only in row 3, full_mode=0 -> done at cycle 2·(cols+2)+1, fail_row=3, syn_weight=1.
- Mask all entries of row 1 with nonzero codeword -> row 1 contributes 0; weight equals row-0 count only.
- block_size_in=0 -> done at cycle 1, cfg_err=1, valid=0; next legal start clears cfg_err.
- abort in CLC, then start while busy ignored, then rst pulse mid-run -> no done, ready=1, outputs at reset values.
